// File: rtl/elastic_pipeline.sv
// Back-pressurable valid/ready pipeline of p_stages register stages with flush and occupancy.
// Build option: define ELASTIC_PIPELINE_RESET_DATA_EN to reset/flush the data registers to 0.
module elastic_pipeline #(
  parameter int p_width  = 32,
  parameter int p_stages = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [p_width-1:0]                i_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [p_width-1:0]                o_data,
  input  logic                              i_flush,
  output logic [$clog2(p_stages+1)-1:0]     o_occupancy
);

  localparam int lp_occ_w = $clog2(p_stages + 1);

  logic [p_stages-1:0] r_valid;
  logic [p_width-1:0]  r_data [p_stages];
  logic [lp_occ_w-1:0] r_occ;

  logic [p_stages-1:0] w_rdy;
  logic [p_stages-1:0] w_vin;
  logic [p_stages-1:0] w_valid_nxt;
  logic [lp_occ_w-1:0] w_occ_nxt;
  logic                w_in_xfer;

  // A stage may load when it is empty or everything downstream of it moves.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_rdy                = '0;
    w_rdy[p_stages-1]    = !r_valid[p_stages-1] || i_ready;
    for (int k = p_stages - 2; k >= 0; k--) begin
      w_rdy[k] = !r_valid[k] || w_rdy[k+1];
    end
  end

  assign o_ready   = w_rdy[0] && !i_rst && !i_flush;
  assign w_in_xfer = i_valid && o_ready;

  always_comb begin
    w_vin    = '0;
    w_vin[0] = w_in_xfer;
    for (int k = 1; k < p_stages; k++) begin
      w_vin[k] = r_valid[k-1];
    end

    w_valid_nxt = r_valid;
    for (int k = 0; k < p_stages; k++) begin
      if (w_rdy[k]) w_valid_nxt[k] = w_vin[k];
    end
    if (i_flush) w_valid_nxt = '0;

    w_occ_nxt = '0;
    for (int k = 0; k < p_stages; k++) begin
      w_occ_nxt = w_occ_nxt + lp_occ_w'(w_valid_nxt[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

`ifdef ELASTIC_PIPELINE_RESET_DATA_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int k = 0; k < p_stages; k++) r_data[k] <= '0;
    end else begin
      if (w_rdy[0] && w_in_xfer) r_data[0] <= i_data;
      for (int k = 1; k < p_stages; k++) begin
        if (w_rdy[k] && w_vin[k]) r_data[k] <= r_data[k-1];
      end
    end
  end
`else
  // NOTE: data registers carry no reset; their content is meaningless while the stage valid is 0.
  always_ff @(posedge i_clk) begin
    if (w_rdy[0] && w_in_xfer) r_data[0] <= i_data;
    for (int k = 1; k < p_stages; k++) begin
      if (w_rdy[k] && w_vin[k]) r_data[k] <= r_data[k-1];
    end
  end
`endif

  assign o_valid     = r_valid[p_stages-1];
  assign o_data      = r_data[p_stages-1];
  assign o_occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline (p_width=8, p_stages=4): directed scenarios plus
// randomized traffic, all checked each cycle against a word-position queue model.
module tb_elastic_pipeline;

  localparam int S = 4;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       i_flush;
  logic [2:0] o_occupancy;

  elastic_pipeline #(.p_width(8), .p_stages(S)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .i_flush     (i_flush),
    .o_occupancy (o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each in-flight word is a (stage position, data) pair, oldest first.
  int         m_pos [$];
  logic [7:0] m_dat [$];
  bit         m_clean = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check outputs against the model, advance the model,
  // then wait until the next negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f,
                       input bit rs, output bit acc);
    bit exp_ready;
    bit exp_vld;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    i_rst   = rs;
    #1;
    exp_ready = ((m_pos.size() < S) || r) && !rs && !f;
    exp_vld   = (m_pos.size() > 0) && (m_pos[0] == S - 1);
    check("o_ready", 32'(o_ready), 32'(exp_ready));
    check("o_valid", 32'(o_valid), 32'(exp_vld));
    check("o_occupancy", 32'(o_occupancy), m_pos.size());
    if (exp_vld) check("o_data", 32'(o_data), 32'(m_dat[0]));
`ifdef ELASTIC_PIPELINE_RESET_DATA_EN
    else if (m_clean) check("o_data_cleared", 32'(o_data), 32'h0);
`endif
    acc = v && exp_ready;
    if (rs || f) begin
      m_pos.delete();
      m_dat.delete();
      m_clean = 1'b1;
    end else begin
      if (exp_vld && r) begin
        void'(m_pos.pop_front());
        void'(m_dat.pop_front());
      end
      // A word advances if the consumer accepts or any stage ahead of it is empty.
      for (int i = 0; i < m_pos.size(); i++) begin
        if (r || ((S - 1 - m_pos[i]) > i)) m_pos[i] = m_pos[i] + 1;
      end
      if (acc) begin
        m_pos.push_back(0);
        m_dat.push_back(d);
      end
      foreach (m_pos[i]) if (m_pos[i] == S - 1) m_clean = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    repeat (n) cycle(1'b0, 8'h00, r, 1'b0, 1'b0, acc);
  endtask

  // Offer a word, holding it until accepted; bounded by a cycle budget.
  task automatic send(input logic [7:0] d, input bit r);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 50) begin
      cycle(1'b1, d, r, 1'b0, 1'b0, acc);
      budget++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'h1);
  endtask

  initial begin
    bit         acc;
    bit         hold;
    logic [7:0] word;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, including o_ready low while reset is held.
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, acc);
    idle(1, 1'b1);

    // Scenario 1: single word, latency p_stages.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, acc);
    idle(3, 1'b1);
    check("s1_valid_c4", 32'(o_valid), 32'h1);
    check("s1_data_c4", 32'(o_data), 32'hA5);
    idle(1, 1'b1);
    check("s1_valid_c5", 32'(o_valid), 32'h0);
    check("s1_occ_c5", 32'(o_occupancy), 32'h0);

    // Scenario 2: back-to-back streaming.
    for (int w = 0; w < 16; w++) send(8'(w), 1'b1);
    idle(S + 1, 1'b1);

    // Scenario 3: back-pressure until full, then release.
    for (int w = 8'h10; w < 8'h14; w++) send(8'(w), 1'b0);
    repeat (3) cycle(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, acc);
    check("s3_full_occ", 32'(o_occupancy), 32'h4);
    check("s3_full_ready", 32'(o_ready), 32'h0);
    send(8'h14, 1'b1);
    send(8'h15, 1'b1);
    idle(S + 2, 1'b1);

    // Scenario 4: bubble collapse under a stalled consumer.
    cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
    idle(4, 1'b0);
    check("s4_occ", 32'(o_occupancy), 32'h2);
    check("s4_ready", 32'(o_ready), 32'h1);
    idle(4, 1'b1);

    // Scenario 5: flush with three words in flight and a word offered.
    for (int w = 1; w <= 3; w++) send(8'(8'h30 + w), 1'b1);
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, acc);
    check("s5_valid_after", 32'(o_valid), 32'h0);
    check("s5_occ_after", 32'(o_occupancy), 32'h0);
    idle(S + 2, 1'b1);

    // Scenario 6: reset in the middle of a stream.
    for (int w = 0; w < 6; w++) send(8'(w), 1'b1);
    repeat (2) cycle(1'b1, 8'h06, 1'b1, 1'b0, 1'b1, acc);
    send(8'h77, 1'b1);
    idle(3, 1'b1);
    check("s6_latency", 32'(o_valid), 32'h1);
    check("s6_data", 32'(o_data), 32'h77);
    idle(2, 1'b1);

    // Randomized traffic with occasional flush and reset.
    hold = 1'b0;
    word = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      bit v;
      bit r;
      bit f;
      bit rs;
      if (!hold) word = 8'($urandom);
      v  = hold || ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 5);
      f  = ($urandom_range(0, 99) < 2);
      rs = ($urandom_range(0, 99) < 1);
      cycle(v, word, r, f, rs, acc);
      hold = v && !acc;
    end
    idle(S + 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
